// File: rtl/keyframe_recorder.sv
// keyframe_recorder: samples a live colour stream on the play tick and
// writes each colour change as a 4-word keyframe into a song slot.
module keyframe_recorder #(
    parameter int ADDR_W = 16,
    parameter int SLOT_W = 10,
    parameter int TIME_W = 12
) (
    input  logic              clock_play,
    input  logic              restart,
    input  logic [3:0]        song_no,
    input  logic              start,
    input  logic              stop,
    input  logic [5:0]        rgb_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [5:0]        mem_wdata,
    output logic              recording,
    output logic              done,
    output logic              overrun,
    output logic [7:0]        rec_count
);

    typedef enum logic [2:0] {
        IDLE,
        W_MSB,
        W_LSB,
        W_NCOL,
        W_COL,
        WAIT,
        DONE
    } state_t;

    // Terminator time and the saturation point just below it.
    localparam logic [TIME_W-1:0] T_TERM = '1;
    localparam logic [TIME_W-1:0] T_SAT  = {{(TIME_W-1){1'b1}}, 1'b0};
    // Last slot offset at which a data record still leaves room
    // for the 4-word terminator at the end of the slot.
    localparam logic [SLOT_W-1:0] LAST_DATA = {{(SLOT_W-3){1'b1}}, 3'b000};

    state_t            state;
    logic [TIME_W-1:0] itime;
    logic [ADDR_W-1:0] wp;
    logic              stop_req;
    logic              term;
    logic [5:0]        ref_color;
    logic [5:0]        last_col;
    logic              pend_v;
    logic [TIME_W-1:0] pend_t;
    logic [5:0]        pend_c;
    logic [TIME_W-1:0] work_t;
    logic [5:0]        work_c;

    logic [ADDR_W-1:0] base_new;
    logic [7:0]        cnt_eff;
    logic              sat;
    logic              room;
    logic              fin;
    logic              chg;
    logic              at_pick;
    logic              take;
    logic              cons;

    assign base_new = {{(ADDR_W-4-SLOT_W){1'b0}}, song_no, {SLOT_W{1'b0}}};

    // Count as it will be once the record now leaving W_COL is counted.
    assign cnt_eff = (state == W_COL && !term) ? rec_count + 8'd1 : rec_count;

    assign sat     = (itime == T_SAT);
    assign room    = (wp[SLOT_W-1:0] <= LAST_DATA) && (cnt_eff != 8'hFF);
    assign fin     = stop_req | sat | ~room;
    assign chg     = recording & ~stop_req & ~sat & (rgb_in != ref_color);
    assign at_pick = (state == WAIT) || (state == W_COL && !term);
    assign take    = pend_v & room;
    assign cons    = at_pick & (take | fin);

    // Recording FSM, change detector and registered memory port.
    always_ff @(posedge clock_play) begin
        if (restart) begin
            state     <= IDLE;
            itime     <= '0;
            wp        <= '0;
            stop_req  <= 1'b0;
            term      <= 1'b0;
            ref_color <= '0;
            last_col  <= '0;
            pend_v    <= 1'b0;
            pend_t    <= '0;
            pend_c    <= '0;
            work_t    <= '0;
            work_c    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            recording <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            rec_count <= '0;
        end else begin
            mem_we <= 1'b0;

            if (recording && !sat)
                itime <= itime + TIME_W'(1);

            if (recording && (stop || sat || !room))
                stop_req <= 1'b1;

            if (cons)
                pend_v <= 1'b0;

            // A change seen on the edge that consumes pending re-arms it.
            if (chg) begin
                pend_v    <= 1'b1;
                pend_t    <= itime;
                pend_c    <= rgb_in;
                ref_color <= rgb_in;
                if (pend_v && !cons)
                    overrun <= 1'b1;
            end

            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= W_MSB;
                        itime     <= '0;
                        wp        <= base_new + ADDR_W'(1);
                        stop_req  <= 1'b0;
                        term      <= 1'b0;
                        ref_color <= rgb_in;
                        last_col  <= rgb_in;
                        pend_v    <= 1'b0;
                        work_t    <= '0;
                        work_c    <= rgb_in;
                        mem_we    <= 1'b1;
                        mem_addr  <= base_new;
                        mem_wdata <= '0;
                        recording <= 1'b1;
                        done      <= 1'b0;
                        overrun   <= 1'b0;
                        rec_count <= '0;
                    end
                end
                W_MSB: begin
                    state     <= W_LSB;
                    mem_we    <= 1'b1;
                    mem_addr  <= wp;
                    mem_wdata <= work_t[5:0];
                    wp        <= wp + ADDR_W'(1);
                end
                W_LSB: begin
                    state     <= W_NCOL;
                    mem_we    <= 1'b1;
                    mem_addr  <= wp;
                    mem_wdata <= 6'd1;
                    wp        <= wp + ADDR_W'(1);
                end
                W_NCOL: begin
                    state     <= W_COL;
                    mem_we    <= 1'b1;
                    mem_addr  <= wp;
                    mem_wdata <= work_c;
                    wp        <= wp + ADDR_W'(1);
                end
                W_COL, WAIT: begin
                    if (state == W_COL && term) begin
                        state     <= DONE;
                        recording <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        if (state == W_COL)
                            rec_count <= rec_count + 8'd1;
                        if (take) begin
                            state     <= W_MSB;
                            term      <= 1'b0;
                            work_t    <= pend_t;
                            work_c    <= pend_c;
                            last_col  <= pend_c;
                            mem_we    <= 1'b1;
                            mem_addr  <= wp;
                            mem_wdata <= pend_t[11:6];
                            wp        <= wp + ADDR_W'(1);
                        end else if (fin) begin
                            state     <= W_MSB;
                            term      <= 1'b1;
                            work_t    <= T_TERM;
                            work_c    <= last_col;
                            mem_we    <= 1'b1;
                            mem_addr  <= wp;
                            mem_wdata <= T_TERM[11:6];
                            wp        <= wp + ADDR_W'(1);
                            if (pend_v)
                                overrun <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/keyframe_recorder.md
Name: keyframe_recorder

Overview:
- Write-side counterpart of the light-stick player.
- Samples a live 6-bit colour stream, one sample per tick of the play clock.
- Encodes every colour change as a keyframe record in the player's memory format and writes it into the song slot selected by song_no.
- Ends the slot with the 0xFFF terminator record, so the player replays the captured sequence with identical timing.

Parameters:
- ADDR_W, 16, memory word-address width.
- SLOT_W, 10, log2 of words per song slot (1024).
- TIME_W, 12, keyframe time width; all-ones is reserved for the terminator.

Ports:
- clock_play  in  1  tick clock, the same tick the player uses.
- restart  in  1  synchronous, active-high reset.
- song_no  in  4  song slot; sampled on start.
- start  in  1  begin recording; accepted only in IDLE or DONE.
- stop  in  1  request end of recording; ignored outside recording.
- rgb_in  in  6  live colour.
- mem_we  out  1  memory write strobe.
- mem_addr  out  16  write address.
- mem_wdata  out  6  write data.
- recording  out  1  high from start acceptance until the terminator is written.
- done  out  1  high after the terminator is written.
- overrun  out  1  sticky; a pending change was overwritten before it was written.
- rec_count  out  8  data records written, excluding the terminator.

Behaviour:
- Record format: 4 consecutive words.
  - time[11:6]
  - time[5:0]
  - nColor = 6'd1
  - colour
- Slot base is {2'b00, song_no, 10'b0}. The write pointer wp starts at base and increments after every written word.
- Reset (restart=1 at an edge): FSM goes to IDLE. All outputs, iTime, wp, the pending register and the stop request clear to 0. Reset mid-record abandons the record; no further writes occur.
- States: IDLE, W_MSB, W_LSB, W_NCOL, W_COL, WAIT, DONE.
- mem_* are registers loaded on the edge that enters a W state.
  - They are valid for exactly the cycle the FSM occupies that state.
  - mem_we=0 in IDLE, WAIT and DONE.
- Start acceptance (in IDLE or DONE), at the edge:
  - iTime <= 0.
  - pending <= {time 0, rgb_in} with valid=1.
  - ref_color <= rgb_in.
  - done, overrun, rec_count clear; recording <= 1.
  - Next state W_MSB, so the first record always has time 0.
- iTime increments by 1 every cycle while recording=1. It saturates at 0xFFE.
- Change detection, every recording cycle while iTime < 0xFFE:
  - If rgb_in != ref_color: pending <= {iTime, rgb_in}, valid=1, ref_color <= rgb_in.
  - If pending was already valid, it is overwritten and overrun <= 1.
- Entering W_MSB latches pending into a work register and clears pending.valid in the same edge. A change on that edge still sets pending.
- Record sequencing:
  - W_MSB -> W_LSB -> W_NCOL -> W_COL, one word per cycle.
  - rec_count increments on exit from W_COL of a data record.
  - After W_COL: go to W_MSB if pending.valid, else WAIT.
- WAIT -> W_MSB when pending.valid.
- Stop conditions. Any of the following sets stop_req; once set it stays until the terminator:
  - stop=1,
  - iTime reaches 0xFFE,
  - wp would pass base+0x3FB (room reserved for the terminator),
  - rec_count = 255.
- With stop_req set:
  - The record in flight completes.
  - A still-pending change is written only if the slot-space limits allow it; otherwise it is dropped and overrun <= 1.
  - The next record is then the terminator: time 0xFFF, nColor 1, colour = ref_color of the last written record.
  - After the terminator's W_COL: DONE, recording <= 0, done <= 1.
- Simultaneous events:
  - stop and an rgb change in the same cycle: the change is captured first, then stop is honoured.
  - start in the same cycle as restart: restart wins.
- DONE holds all outputs until start or restart.

Test Plan:
- restart, song_no=2, rgb_in=6'h33, start, stop 10 cycles later -> writes at 0x0800..0x0803 = 00,00,01,33, then terminator at 0x0804..0x0807 = 3F,3F,01,33; rec_count=1; done=1.
- Start, rgb_in changes to 6'h0C with iTime=0x045 -> record 01,05,01,0C written in four consecutive cycles; rec_count=2 after stop.
- Two changes 1 cycle apart while a record is in flight -> only the second is written (with its own time); overrun=1.
- No stop for 0xFFE cycles -> terminator written automatically; iTime holds at 0xFFE; done=1.
- Toggle rgb_in every 5 cycles -> exactly 255 data records, then the terminator at base+0x3FC..0x3FF; no write outside the slot.
- restart asserted during W_LSB -> mem_we=0 from the next cycle; recording=0 and done=0; a following start rewrites from base.
